vid_tpg_timing: RTL and testbench

- Parametrised video timing generator with a built-in multi-mode test pattern source.
- Successor to the fixed 1280x720 TPG path in the video-input stage. Adds generic resolution and porch parameters, selectable pixel width, six pattern modes, frame-synchronous mode switching and a frame counter.
- Output is a VS/HS/DE/data stream. It feeds the video-processing stage directly, in place of the camera path, when that stage is built with the TPG option.

---
 rtl/vid_pkg.sv | 48 ++++
 rtl/vid_timing_core.sv | 109 ++++++++++
 rtl/vid_tpg_timing.sv | 169 ++++++++++++++++
 tb/tb_vid_tpg_timing.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared definitions for the video timing / test pattern blocks:
// pattern mode encodings, colour constants and the timing-total helper.
package vid_pkg;

    typedef enum logic [2:0] {
        MODE_BARS   = 3'd0,
        MODE_HRAMP  = 3'd1,
        MODE_VRAMP  = 3'd2,
        MODE_CHECK  = 3'd3,
        MODE_SOLID  = 3'd4,
        MODE_MOVBAR = 3'd5
    } mode_e;

    // The encoding order matches the left-to-right colour bar order.
    typedef enum logic [2:0] {
        C_WHITE   = 3'd0,
        C_YELLOW  = 3'd1,
        C_CYAN    = 3'd2,
        C_GREEN   = 3'd3,
        C_MAGENTA = 3'd4,
        C_RED     = 3'd5,
        C_BLUE    = 3'd6,
        C_BLACK   = 3'd7
    } color_e;

    localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB565_RED     = 16'hF800;
    localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE    = 16'h001F;
    localparam logic [15:0] RGB565_YELLOW  = RGB565_RED | RGB565_GREEN;
    localparam logic [15:0] RGB565_CYAN    = RGB565_GREEN | RGB565_BLUE;
    localparam logic [15:0] RGB565_MAGENTA = RGB565_RED | RGB565_BLUE;
    localparam logic [15:0] RGB565_BLACK   = 16'h0000;

    localparam logic [23:0] RGB888_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB888_RED     = 24'hFF0000;
    localparam logic [23:0] RGB888_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB888_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB888_YELLOW  = RGB888_RED | RGB888_GREEN;
    localparam logic [23:0] RGB888_CYAN    = RGB888_GREEN | RGB888_BLUE;
    localparam logic [23:0] RGB888_MAGENTA = RGB888_RED | RGB888_BLUE;
    localparam logic [23:0] RGB888_BLACK   = 24'h000000;

    function automatic int totals(input int disp, input int fp, input int sync, input int bp);
        return disp + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vid_timing_core.sv
// Horizontal/vertical raster counters with registered sync, DE, x/y and
// frame_start; counters stay parked at (0,0) until en has been high a full cycle.
module vid_timing_core
    import vid_pkg::*;
#(
    parameter int H_DISP   = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_DISP   = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [11:0] h_cnt,
    output logic [11:0] v_cnt,
    output logic        adv,
    output logic        origin,
    output logic        active,
    output logic        line_wrap,
    output logic        frame_wrap,
    output logic        vs,
    output logic        hs,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start
);

    localparam int H_TOTAL = totals(H_DISP, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = totals(V_DISP, V_FP, V_SYNC, V_BP);

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_DISP);
    localparam logic [11:0] V_ACT  = 12'(V_DISP);
    localparam logic [11:0] HS_BEG = 12'(H_DISP + H_FP);
    localparam logic [11:0] HS_END = 12'(H_DISP + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG = 12'(V_DISP + V_FP);
    localparam logic [11:0] VS_END = 12'(V_DISP + V_FP + V_SYNC);

    logic run;
    logic hs_act;
    logic vs_act;

    assign adv        = en & run;
    assign origin     = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign line_wrap  = adv && (h_cnt == H_LAST);
    assign frame_wrap = line_wrap && (v_cnt == V_LAST);
    assign hs_act     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_act     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    // run marks that en was already high last cycle, giving one parked (0,0) cycle.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would chain the updates within one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= 1'b0;
        end else begin
            run <= en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!adv) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs          <= ~SYNC_POL;
            hs          <= ~SYNC_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else if (!adv) begin
            vs          <= ~SYNC_POL;
            hs          <= ~SYNC_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            vs          <= vs_act ? SYNC_POL : ~SYNC_POL;
            hs          <= hs_act ? SYNC_POL : ~SYNC_POL;
            de          <= active;
            x           <= active ? h_cnt : 12'd0;
            y           <= active ? v_cnt : 12'd0;
            frame_start <= origin;
        end
    end

endmodule

// File: rtl/vid_tpg_timing.sv
// Video timing generator with a frame-synchronous multi-mode test pattern
// source (bars, ramps, checkerboard, solid, moving bar) and a frame counter.
module vid_tpg_timing
    import vid_pkg::*;
#(
    parameter int H_DISP   = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_DISP   = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int DATA_W   = 16,
    parameter bit SYNC_POL = 1'b1,
    parameter int CHK_LOG2 = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] solid_color,
    output logic              vs,
    output logic              hs,
    output logic              de,
    output logic [DATA_W-1:0] data,
    output logic [11:0]       x,
    output logic [11:0]       y,
    output logic              frame_start,
    output logic [15:0]       frame_cnt
);

    generate
        if (DATA_W != 16 && DATA_W != 24) begin : g_bad_data_w
            $error("vid_tpg_timing: DATA_W must be 16 (RGB565) or 24 (RGB888)");
        end
    endgenerate

    localparam int BAR_W = H_DISP / 8;
    localparam int BPX_W = $clog2(BAR_W + 1);
    localparam logic [BPX_W-1:0] BPX_LAST = BPX_W'(BAR_W - 1);
    localparam logic [11:0] H_ACT    = 12'(H_DISP);
    localparam logic [11:0] POS_LAST = 12'(H_DISP - 1);

    logic [11:0] h_cnt, v_cnt;
    logic        adv, origin, active, line_wrap, frame_wrap;

    vid_timing_core #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL)
    ) u_core (
        .clk(clk), .rst(rst), .en(en),
        .h_cnt(h_cnt), .v_cnt(v_cnt),
        .adv(adv), .origin(origin), .active(active),
        .line_wrap(line_wrap), .frame_wrap(frame_wrap),
        .vs(vs), .hs(hs), .de(de), .x(x), .y(y),
        .frame_start(frame_start)
    );

    function automatic logic [DATA_W-1:0] rgb(input color_e c);
        logic [15:0] c565;
        logic [23:0] c888;
        case (c)
            C_WHITE:   begin c565 = RGB565_WHITE;   c888 = RGB888_WHITE;   end
            C_YELLOW:  begin c565 = RGB565_YELLOW;  c888 = RGB888_YELLOW;  end
            C_CYAN:    begin c565 = RGB565_CYAN;    c888 = RGB888_CYAN;    end
            C_GREEN:   begin c565 = RGB565_GREEN;   c888 = RGB888_GREEN;   end
            C_MAGENTA: begin c565 = RGB565_MAGENTA; c888 = RGB888_MAGENTA; end
            C_RED:     begin c565 = RGB565_RED;     c888 = RGB888_RED;     end
            C_BLUE:    begin c565 = RGB565_BLUE;    c888 = RGB888_BLUE;    end
            default:   begin c565 = RGB565_BLACK;   c888 = RGB888_BLACK;   end
        endcase
        return (DATA_W == 16) ? DATA_W'(c565) : DATA_W'(c888);
    endfunction

    // Each component takes the MSB-aligned bits of the 8-bit ramp value.
    function automatic logic [DATA_W-1:0] ramp(input logic [7:0] b);
        logic [15:0] r565;
        logic [23:0] r888;
        r565 = {b[7:3], b[7:2], b[7:3]};
        r888 = {b, b, b};
        return (DATA_W == 16) ? DATA_W'(r565) : DATA_W'(r888);
    endfunction

    logic [2:0]        mode_q;
    logic [DATA_W-1:0] solid_q;
    logic [2:0]        eff_mode;
    logic [DATA_W-1:0] eff_solid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= '0;
            solid_q <= '0;
        end else if (en && origin) begin
            mode_q  <= mode;
            solid_q <= solid_color;
        end
    end

    // The first pixel of a frame is computed in the same cycle the latch loads.
    assign eff_mode  = origin ? mode : mode_q;
    assign eff_solid = origin ? solid_color : solid_q;

    logic [BPX_W-1:0] bar_px;
    logic [2:0]       bar_idx;
    logic [11:0]      bar_pos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (!adv || line_wrap) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (h_cnt < H_ACT) begin
            if (bar_px == BPX_LAST) begin
                bar_px <= '0;
                if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px <= bar_px + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_pos   <= '0;
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            bar_pos   <= (bar_pos == POS_LAST) ? 12'd0 : bar_pos + 12'd1;
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    logic [11:0]       chk_xy;
    logic              in_bar;
    logic [DATA_W-1:0] pix;

    assign chk_xy = (h_cnt >> CHK_LOG2) ^ (v_cnt >> CHK_LOG2);
    assign in_bar = ({1'b0, h_cnt} >= {1'b0, bar_pos}) &&
                    ({1'b0, h_cnt} <= {1'b0, bar_pos} + 13'd7);

    // NOTE: pix gets a default before the case so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        pix = '0;
        case (mode_e'(eff_mode))
            MODE_BARS:   pix = rgb(color_e'(bar_idx));
            MODE_HRAMP:  pix = ramp(h_cnt[7:0]);
            MODE_VRAMP:  pix = ramp(v_cnt[7:0]);
            MODE_CHECK:  pix = chk_xy[0] ? rgb(C_WHITE) : rgb(C_BLACK);
            MODE_SOLID:  pix = eff_solid;
            MODE_MOVBAR: pix = in_bar ? rgb(C_WHITE) : rgb(C_BLACK);
            default:     pix = rgb(C_BLACK);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (!adv) begin
            data <= '0;
        end else begin
            data <= active ? pix : '0;
        end
    end

endmodule

// File: tb/tb_vid_tpg_timing.sv
// Directed bench for vid_tpg_timing on a 22x7 raster: a raster model pushes the
// expected output of every cycle into a queue, which is popped after the edge.
module tb_vid_tpg_timing;

    localparam int HD = 16, HF = 2, HS = 2, HB = 2;
    localparam int VD = 4,  VF = 1, VS = 1, VB = 1;
    localparam int HT = HD + HF + HS + HB;   // 22
    localparam int VT = VD + VF + VS + VB;   // 7
    localparam int FR = HT * VT;             // 154

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [15:0] data;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  mode;
    logic [15:0] solid_color;
    logic        vs, hs, de, frame_start;
    logic [15:0] data, frame_cnt;
    logic [11:0] x, y;
    obs_t        obs_now;

    always #5 clk = ~clk;

    vid_tpg_timing #(
        .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .DATA_W(16), .SYNC_POL(1'b0), .CHK_LOG2(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_color(solid_color),
        .vs(vs), .hs(hs), .de(de), .data(data), .x(x), .y(y),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    assign obs_now = {vs, hs, de, data, x, y, frame_start, frame_cnt};

    int total = 0;
    int bad   = 0;

    // Raster model state
    bit          m_run;
    int          m_h, m_v, m_mode, m_pos, m_fc;
    logic [15:0] m_solid;
    obs_t        exp_q[$];

    // Run statistics
    int          n_de, n_hs, n_vs, ncyc, last_fs, fs_gap, first_fs, first_white;
    logic [15:0] pix_log [0:VD-1][0:HD-1];

    logic [15:0] bars [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    function automatic obs_t idle_obs(input int fc);
        obs_t o;
        o = '0;
        o.vs = 1'b1;
        o.hs = 1'b1;
        o.fc = 16'(fc);
        return o;
    endfunction

    function automatic logic [15:0] model_pix(input int md, input int px, input int py,
                                              input logic [15:0] sc, input int pos);
        logic [7:0] b;
        case (md)
            0: return bars[(px / 2 > 7) ? 7 : px / 2];
            1: begin b = 8'(px); return {b[7:3], b[7:2], b[7:3]}; end
            2: begin b = 8'(py); return {b[7:3], b[7:2], b[7:3]}; end
            3: return ((((px >> 1) ^ (py >> 1)) & 1) != 0) ? 16'hFFFF : 16'h0000;
            4: return sc;
            5: return (px >= pos && px <= pos + 7) ? 16'hFFFF : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_run = 1'b0; m_h = 0; m_v = 0; m_mode = 0; m_solid = '0; m_pos = 0; m_fc = 0;
        exp_q.delete();
    endtask

    // Expected output after the coming edge, given the inputs now being driven.
    task automatic model_step(output obs_t e);
        bit          org;
        int          md;
        logic [15:0] sc;
        e = idle_obs(m_fc);
        if (!en) begin
            m_h = 0; m_v = 0; m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
            if (m_h == 0 && m_v == 0) begin m_mode = int'(mode); m_solid = solid_color; end
        end else begin
            org = (m_h == 0 && m_v == 0);
            md  = org ? int'(mode) : m_mode;
            sc  = org ? solid_color : m_solid;
            if (org) begin m_mode = int'(mode); m_solid = solid_color; end
            e.de   = (m_h < HD) && (m_v < VD);
            e.hs   = (m_h >= HD + HF && m_h < HD + HF + HS) ? 1'b0 : 1'b1;
            e.vs   = (m_v >= VD + VF && m_v < VD + VF + VS) ? 1'b0 : 1'b1;
            e.x    = e.de ? 12'(m_h) : 12'd0;
            e.y    = e.de ? 12'(m_v) : 12'd0;
            e.data = e.de ? model_pix(md, m_h, m_v, sc, m_pos) : 16'h0000;
            e.fs   = org;
            if (m_h == HT - 1) begin
                m_h = 0;
                if (m_v == VT - 1) begin
                    m_v   = 0;
                    m_fc  = (m_fc + 1) & 16'hFFFF;
                    m_pos = (m_pos == HD - 1) ? 0 : m_pos + 1;
                end else begin
                    m_v = m_v + 1;
                end
            end else begin
                m_h = m_h + 1;
            end
            e.fc = 16'(m_fc);
        end
    endtask

    task automatic chk_obs(input string tag, input obs_t g, input obs_t e);
        total++;
        assert (g === e) else begin
            bad++;
            $error("FAIL %s: got vs=%b hs=%b de=%b x=%0d y=%0d data=%h fs=%b fc=%0d, want vs=%b hs=%b de=%b x=%0d y=%0d data=%h fs=%b fc=%0d",
                   tag, g.vs, g.hs, g.de, g.x, g.y, g.data, g.fs, g.fc,
                   e.vs, e.hs, e.de, e.x, e.y, e.data, e.fs, e.fc);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic clear_stats();
        n_de = 0; n_hs = 0; n_vs = 0; ncyc = 0; last_fs = 0; fs_gap = 0;
        first_fs = -1; first_white = -1;
    endtask

    task automatic cyc(input string tag);
        obs_t e, g;
        model_step(e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = obs_now;
        e = exp_q.pop_front();
        chk_obs(tag, g, e);
        ncyc++;
        if (g.de) n_de++;
        if (!g.hs) n_hs++;
        if (!g.vs) n_vs++;
        if (g.fs) begin
            fs_gap  = ncyc - last_fs;
            last_fs = ncyc;
            first_white = -1;
            if (first_fs < 0) first_fs = ncyc;
        end
        if (g.de && g.y < VD && g.x < HD) pix_log[g.y][g.x] = g.data;
        if (g.de && g.y == 0 && g.data == 16'hFFFF && first_white < 0) first_white = int'(g.x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; mode = 3'd0; solid_color = 16'h0000;
        model_reset();
        clear_stats();
        #1 chk_obs("reset_state", obs_now, idle_obs(0));

        // Colour bars, two full frames after enable
        @(negedge clk);
        rst = 1'b0; en = 1'b1;
        cyc("en_park");
        clear_stats();
        repeat (2 * FR) cyc("bars");
        chk("de_per_2frames", n_de, 2 * HD * VD);
        chk("hs_act_per_2frames", n_hs, 2 * HS * VT);
        chk("vs_act_per_2frames", n_vs, 2 * VS * HT);
        chk("frame_period", fs_gap, FR);
        chk("bar0_x0", pix_log[0][0], 16'hFFFF);
        chk("bar1_x2", pix_log[0][2], 16'hFFE0);
        chk("bar7_x14", pix_log[0][14], 16'h0000);
        chk("bar7_x15", pix_log[3][15], 16'h0000);

        // Mid-frame mode change takes effect at the next frame
        repeat (50) cyc("bars_head");
        mode = 3'd4; solid_color = 16'h1234;
        repeat (FR - 50) cyc("bars_tail");
        chk("bars_kept_line3", pix_log[3][0], 16'hFFFF);
        cyc("solid_first");
        chk("solid_first_px", obs_now.data, 16'h1234);
        chk("solid_first_fs", obs_now.fs, 1'b1);

        // Checkerboard with 2-pixel squares
        mode = 3'd3;
        repeat (FR - 1) cyc("solid");
        chk("solid_last_px", pix_log[3][15], 16'h1234);
        repeat (FR) cyc("check");
        chk("chk_x2_y0", pix_log[0][2], 16'hFFFF);
        chk("chk_x0_y0", pix_log[0][0], 16'h0000);
        chk("chk_x2_y2", pix_log[2][2], 16'h0000);
        chk("chk_x2_y1", pix_log[1][2], 16'hFFFF);

        // Asynchronous reset mid-line, then release with en high
        repeat (30) cyc("pre_rst");
        #2 rst = 1'b1;
        #1 chk_obs("async_rst", obs_now, idle_obs(0));
        model_reset();
        mode = 3'd5;
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
        cyc("rel_park");
        chk("rel_no_fs", obs_now.fs, 1'b0);

        // Moving bar over 18 frames
        for (int k = 0; k < 18; k++) begin
            repeat (FR) cyc("movbar");
            chk($sformatf("bar_pos_f%0d", k), first_white, k % HD);
        end
        chk("rel_fs_2nd_edge", first_fs, 2);
        chk("frame_cnt_18", frame_cnt, 16'd18);

        // Drop en inside line 2, then restart a full frame
        repeat (2 * HT + 5) cyc("to_line2");
        en = 1'b0;
        cyc("en_off");
        chk("off_de", obs_now.de, 1'b0);
        chk("off_frame_cnt", frame_cnt, 16'd18);
        repeat (5) cyc("idle");
        en = 1'b1;
        cyc("re_park");
        cyc("re_first");
        chk("re_fs", obs_now.fs, 1'b1);
        chk("re_xy", {obs_now.x, obs_now.y}, 24'h000000);
        repeat (FR - 1) cyc("re_frame");
        chk("frame_cnt_19", frame_cnt, 16'd19);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
